// File: rtl/alu_scheduler.sv
// alu_scheduler: round-robin sequencer sharing one combinational ALU between two requesters.
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   req0_* / req1_*               valid/ready request channels carrying {op, a, b}
//   alu_op, alu_a, alu_b, alu_out shared ALU interface (operands registered, result sampled)
//   rsp_*                         valid/ready response channel with id, data and Z/N/V/err flags

package alu_scheduler_pkg;

    localparam int unsigned OP_W = 4;

    // Opcode set of the shared ALU; codes 8..15 are undefined and return 0.
    typedef enum logic [OP_W-1:0] {
        OP_AND  = 4'd0,
        OP_OR   = 4'd1,
        OP_XOR  = 4'd2,
        OP_ADD  = 4'd3,
        OP_SUB  = 4'd4,
        OP_MULT = 4'd5,
        OP_DIV  = 4'd6,
        OP_MOD  = 4'd7
    } op_code_e;

endpackage

module alu_scheduler
    import alu_scheduler_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst,

    input  logic         req0_valid,
    output logic         req0_ready,
    input  op_code_e     req0_op,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,

    input  logic         req1_valid,
    output logic         req1_ready,
    input  op_code_e     req1_op,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,

    output op_code_e     alu_op,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    input  logic [N-1:0] alu_out,

    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [N-1:0] rsp_data,
    output logic         rsp_z,
    output logic         rsp_n,
    output logic         rsp_v,
    output logic         rsp_err
);

    localparam int unsigned MSB = N - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e       state;
    logic         last_grant;
    logic         id_q;

    logic         grant;
    logic         accept;
    logic         div_zero;
    logic [N-1:0] result;
    logic         ovf;

    // Arbitration: sole requester wins; on contention the one not granted last time wins.
    always_comb begin
        grant      = 1'b0;
        accept     = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else begin
            grant = req1_valid;
        end
        accept     = (state == S_IDLE) && (req0_valid || req1_valid);
        req0_ready = accept && !grant;
        req1_ready = accept && grant;
    end

    // Result and flags from the latched operands and the ALU output.
    always_comb begin
        div_zero = 1'b0;
        result   = alu_out;
        ovf      = 1'b0;
        if ((alu_op == OP_DIV || alu_op == OP_MOD) && (alu_b == '0)) begin
            div_zero = 1'b1;
            result   = '0;
        end
        case (alu_op)
            OP_ADD:  ovf = (alu_a[MSB] == alu_b[MSB]) && (result[MSB] != alu_a[MSB]);
            OP_SUB:  ovf = (alu_a[MSB] != alu_b[MSB]) && (result[MSB] != alu_a[MSB]);
            default: ovf = 1'b0;
        endcase
    end

    // Sequencer: IDLE accepts, EXEC samples the ALU, RESP holds until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            last_grant <= 1'b1;
            id_q       <= 1'b0;
            alu_op     <= OP_AND;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
            rsp_z      <= 1'b0;
            rsp_n      <= 1'b0;
            rsp_v      <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        alu_op     <= grant ? req1_op : req0_op;
                        alu_a      <= grant ? req1_a  : req0_a;
                        alu_b      <= grant ? req1_b  : req0_b;
                        id_q       <= grant;
                        last_grant <= grant;
                        state      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    rsp_valid <= 1'b1;
                    rsp_id    <= id_q;
                    rsp_data  <= result;
                    rsp_z     <= (result == '0);
                    rsp_n     <= result[MSB];
                    rsp_v     <= ovf;
                    rsp_err   <= div_zero;
                    state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
